// File: rtl/cordic_pkg.sv
// Shared constants for the bfloat16 CORDIC engines: atan ROM, pi/2, 1/K,
// FSM state encoding and bfloat16 field widths.
package cordic_pkg;

  localparam int CORDIC_W    = 24;
  localparam int CORDIC_FRAC = 14;
  localparam int ITER_MAX    = 16;

  localparam int BF_SIGN_W = 1;
  localparam int BF_EXP_W  = 8;
  localparam int BF_MANT_W = 7;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  // Angles and gain in Q10.14
  localparam logic signed [CORDIC_W-1:0] PI_HALF = 24'sd25736;
  localparam logic signed [CORDIC_W-1:0] INV_K   = 24'sd9949;

  localparam logic signed [CORDIC_W-1:0] ATAN_ROM [ITER_MAX] = '{
    24'sd12868, 24'sd7596, 24'sd4014, 24'sd2037,
    24'sd1023,  24'sd512,  24'sd256,  24'sd128,
    24'sd64,    24'sd32,   24'sd16,   24'sd8,
    24'sd4,     24'sd2,    24'sd1,    24'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fixed_to_bf16.sv
// Combinational normaliser: signed fixed point (FRAC fractional bits) to
// bfloat16 with a truncated mantissa; zero maps to +0.
module fixed_to_bf16
  import cordic_pkg::*;
#(
  parameter int W    = CORDIC_W,
  parameter int FRAC = CORDIC_FRAC
) (
  input  logic signed [W-1:0] i_fix,
  output logic [15:0]         o_bf
);

  localparam int PW = $clog2(W);

  logic [W-1:0]           w_abs;
  logic [W+BF_MANT_W-1:0] w_ext;
  logic [PW-1:0]          w_pos;
  logic [BF_EXP_W-1:0]    w_exp;
  logic [BF_MANT_W-1:0]   w_mant;

  assign w_abs = i_fix[W-1] ? -i_fix : i_fix;

  always_comb begin
    w_pos = '0;
    for (int k = 0; k < W; k++) begin
      if (w_abs[k]) w_pos = PW'(k);
    end
  end

  // Zero padding below the LSB lets small values keep a full 7-bit mantissa
  assign w_ext  = {w_abs, {BF_MANT_W{1'b0}}};
  assign w_mant = BF_MANT_W'(w_ext >> w_pos);
  assign w_exp  = BF_EXP_W'(w_pos) + BF_EXP_W'(127 - FRAC);
  assign o_bf   = (w_abs == '0) ? 16'h0000 : {i_fix[W-1], w_exp, w_mant};

endmodule

// File: rtl/cordic_vectoring_bf16.sv
// Iterative vectoring-mode CORDIC: bfloat16 (x, y) -> magnitude, atan2(y, x).
// Define CORDIC_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain K.
module cordic_vectoring_bf16
  import cordic_pkg::*;
#(
  parameter int ITER = 12,
  parameter int W    = CORDIC_W,
  parameter int FRAC = CORDIC_FRAC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_mag,
  output logic [15:0] out_ang,
  output logic        out_err
);

  state_e              r_state;
  logic [4:0]          r_iter;
  logic signed [W-1:0] r_x, r_y, r_z;
  logic                r_zero;

  logic                w_err_in, w_last;
  logic signed [W-1:0] w_xin, w_yin, w_xpre, w_ypre, w_zpre;
  logic signed [W-1:0] w_xs, w_ys, w_atan, w_x_nxt, w_y_nxt, w_z_nxt;
  logic signed [W-1:0] w_mag_src, w_ang_src;
  logic [15:0]         w_mag_bf, w_ang_bf, w_mag_out, w_ang_out;

  function automatic logic signed [W-1:0] bf16_to_fixed(input logic [15:0] v);
    logic [7:0]   e;
    logic [W-1:0] m;
    e = v[14:7];
    m = W'({1'b1, v[6:0]});
    if (e < 8'd112) m = '0;
    else if (e >= 8'd120) m = m << (e - 8'd120);
    else m = m >> (8'd120 - e);
    bf16_to_fixed = v[15] ? -$signed(m) : $signed(m);
  endfunction

  assign w_err_in  = (in_x[14:7] >= 8'd134) || (in_y[14:7] >= 8'd134);
  assign w_xin     = bf16_to_fixed(in_x);
  assign w_yin     = bf16_to_fixed(in_y);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_last    = (r_iter == 5'(ITER - 1));

  // Left half-plane is folded into the right half so the iterations converge
  always_comb begin
    w_xpre = w_xin;
    w_ypre = w_yin;
    w_zpre = '0;
    if (w_xin[W-1]) begin
      if (!w_yin[W-1]) begin
        w_xpre = w_yin;
        w_ypre = -w_xin;
        w_zpre = W'(PI_HALF);
      end else begin
        w_xpre = -w_yin;
        w_ypre = w_xin;
        w_zpre = -W'(PI_HALF);
      end
    end
  end

  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = W'(ATAN_ROM[r_iter[3:0]]);

  always_comb begin
    if (!r_y[W-1]) begin
      w_x_nxt = r_x + w_ys;
      w_y_nxt = r_y - w_xs;
      w_z_nxt = r_z + w_atan;
    end else begin
      w_x_nxt = r_x - w_ys;
      w_y_nxt = r_y + w_xs;
      w_z_nxt = r_z - w_atan;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [W-1:0]   w_invk;
  logic signed [2*W-1:0] w_prod;
  assign w_invk    = W'(INV_K);
  assign w_prod    = (2*W)'(r_x) * (2*W)'(w_invk);
  assign w_mag_src = W'(w_prod >>> FRAC);
  assign w_ang_src = r_z;
`else
  assign w_mag_src = w_x_nxt;
  assign w_ang_src = w_z_nxt;
`endif

  fixed_to_bf16 #(.W(W), .FRAC(FRAC)) u_mag_norm (
    .i_fix (w_mag_src),
    .o_bf  (w_mag_bf)
  );

  fixed_to_bf16 #(.W(W), .FRAC(FRAC)) u_ang_norm (
    .i_fix (w_ang_src),
    .o_bf  (w_ang_bf)
  );

  assign w_mag_out = w_mag_bf & 16'h7FFF;
  assign w_ang_out = r_zero ? 16'h0000 : w_ang_bf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_iter  <= '0;
      out_mag <= 16'h0000;
      out_ang <= 16'h0000;
      out_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_iter <= '0;
            if (w_err_in) begin
              r_state <= ST_DONE;
              out_err <= 1'b1;
              out_mag <= BF16_QNAN;
              out_ang <= BF16_QNAN;
            end else begin
              r_state <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          r_iter <= r_iter + 5'd1;
          if (w_last) begin
`ifdef CORDIC_GAIN_COMP_EN
            r_state <= ST_SCALE;
`else
            r_state <= ST_DONE;
            out_err <= 1'b0;
            out_mag <= w_mag_out;
            out_ang <= w_ang_out;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_SCALE: begin
          r_state <= ST_DONE;
          out_err <= 1'b0;
          out_mag <= w_mag_out;
          out_ang <= w_ang_out;
        end
`endif
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; validity comes from r_state alone
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && in_valid) begin
      r_x    <= w_xpre;
      r_y    <= w_ypre;
      r_z    <= w_zpre;
      r_zero <= (w_xin == '0) && (w_yin == '0);
    end else if (r_state == ST_ITER) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_z <= w_z_nxt;
    end
  end

endmodule

// File: doc/cordic_vectoring_bf16.md
# cordic_vectoring_bf16

Iterative CORDIC engine in vectoring mode for the bfloat16 datapath: it takes a Cartesian vector (x, y) and returns its magnitude and its angle atan2(y, x), both in bfloat16. It is the inverse of the rotation-mode CORDIC, which turns an angle into sin/cos. The block sits beside the bfloat16 adder in the CORDIC architecture. Internally it converts to signed fixed point, runs one micro-rotation per cycle, and renormalises the results to bfloat16.

## Interface
- ITER, 12, number of micro-rotations (1..FRAC).
- W, 24, internal signed fixed-point width.
- FRAC, 14, fractional bits of the internal format.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_x  in  16  bfloat16 x component.
- in_y  in  16  bfloat16 y component.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts the results.
- out_mag  out  16  bfloat16 magnitude (sign bit always 0).
- out_ang  out  16  bfloat16 angle in radians, range [-π, π].
- out_err  out  1  input was NaN/Inf or out of range.

## Operation
- FSM states: IDLE, ITER, SCALE (only with the macro), DONE.
- IDLE: on in_valid & in_ready, convert and load the inputs, clear the iteration counter, go to ITER.
  - If either input has exp == 0xFF or |v| ≥ 128 (exp ≥ 134), go straight to DONE instead.
  - In that case out_err = 1 and out_mag = out_ang = 0x7FC0.
- bf16→fixed conversion:
  - exp == 0 (zero/denormal) → 0.
  - Otherwise magnitude = {1, mant} shifted left by (exp − 120); a negative shift amount means a right shift with truncation.
  - A shift below −8 gives 0.
  - Negate when the sign bit is set.
- Pre-rotation on load:
  - x < 0, y ≥ 0 → x' = y, y' = −x, z = +π/2.
  - x < 0, y < 0 → x' = −y, y' = x, z = −π/2.
  - Otherwise x' = x, y' = y, z = 0.
- ITER, step i:
  - y ≥ 0 → x += y>>>i, y −= x>>>i, z += atan(2^−i).
  - y < 0 → the opposite signs.
  - Shifts are arithmetic; all updates use pre-step values; wrap-free by range limit.
- After step ITER−1: go to SCALE if the macro is defined, else to DONE.
- Entering DONE: x and z are converted by the normaliser and registered into out_mag and out_ang.
- Zero vector (both converted inputs 0) → out_ang forced to 0x0000.
- fixed→bf16 conversion:
  - Leading-one position p of |v|; exp = p − FRAC + 127.
  - Mantissa = the 7 bits below the leading one, truncated.
  - v == 0 → 0x0000.
- DONE: out_valid = 1, outputs held stable. On out_ready go to IDLE; out_valid drops on that edge.

## Timing
- Reset values: out_valid 0, out_mag 0x0000, out_ang 0x0000, out_err 0, state IDLE. in_ready reads 1 during and after reset.
- Latency from accept edge to out_valid high:
  - ITER cycles (12 at default).
  - ITER+1 with the macro.
  - 1 on error.
- in_ready stays low from the accept edge until the DONE→IDLE edge. Throughput is one vector per ITER+2 cycles minimum.
- out_ready high while not in DONE has no effect.
- rst_n low mid-operation: the in-flight vector is discarded, with no partial out_valid.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - The SCALE state multiplies x by the 1/K constant (0.607253, FRAC bits) in one cycle.
  - out_mag is the true magnitude.
- Not defined:
  - No SCALE state.
  - out_mag = K·|v| with K ≈ 1.6468; (3, 4) yields 0x4103.

## Structure
- Shared package cordic_pkg holds:
  - the atan(2^−i) ROM constants in Q(W−FRAC).FRAC (ITER_MAX = 16 entries);
  - PI_HALF and INV_K;
  - the state enum;
  - the bf16 field-width constants (1/8/7).
- One sub-module, fixed_to_bf16: combinational leading-one normaliser, instantiated twice (magnitude, angle).

## Test plan
- in_x = 0x4040 (3.0), in_y = 0x4080 (4.0), macro on → after 13 cycles: out_mag 0x40A0 ±1 ulp, out_ang 0x3F6D ±1 ulp, out_err 0.
- in_x = 0xBF80 (−1.0), in_y = 0x0000 → out_mag 0x3F80 ±1 ulp, out_ang 0x4049 ±1 ulp (π).
- in_x = in_y = 0x0000 → out_mag 0x0000, out_ang 0x0000, out_err 0.
- in_x = 0x7FC0 (NaN) → one cycle later: out_valid 1, out_err 1, out_mag = out_ang = 0x7FC0.
- out_ready held low 5 cycles in DONE → outputs and out_valid unchanged, in_ready 0; after release, the next vector is accepted in IDLE.
- rst_n pulsed low at iteration 6 → immediately out_valid 0 and outputs 0x0000; in_ready 1; the next vector completes normally.
